btn_debounce_pulse: RTL

- Conditions a raw, asynchronous push-button or switch input into clean control signals for the lab's enabled D flip-flop stages.
- Sits directly upstream of the D flip-flop block and drives its D (clean level) and en (one-cycle edge pulses).
- Synchronises the input, debounces it with a stability counter, and emits single-cycle rise/fall pulses.
- Also keeps a wrapping count of debounced presses.

---
 rtl/btn_pkg.sv | 12 +
 rtl/sync_2ff.sv | 19 +
 rtl/btn_debounce_pulse.sv | 99 +++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: shared state encoding and default sizing for the button debouncer
package btn_pkg;
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;
  localparam int STABLE_CYCLES_DEF = 4;
  localparam int CNT_W_DEF         = 20;
  localparam int PRESS_W_DEF       = 8;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_s1, r_s2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end
  assign o_q = r_s2;
endmodule

// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: synchronise, debounce and edge-pulse a raw button, counting accepted presses
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int PRESS_W       = PRESS_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_in,
  input  logic               en,
  output logic               btn_level,
  output logic               rise_pulse,
  output logic               fall_pulse,
  output logic               busy,
  output logic [PRESS_W-1:0] press_count
);
  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);
  logic               w_s2;
  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               w_rise, w_fall;
  logic               r_level, r_rise, r_fall, r_busy;
  logic [PRESS_W-1:0] r_press;
  sync_2ff u_sync (
    .clk (clk),
    .rst (reset),
    .i_d (btn_in),
    .o_q (w_s2)
  );
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    if (en) begin
      case (r_state)
        IDLE_LOW: if (w_s2) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = CNT_W'(1);
        end
        WAIT_HIGH: if (!w_s2) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STABLE) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
          w_rise      = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
        IDLE_HIGH: if (!w_s2) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = CNT_W'(1);
        end
        WAIT_LOW: if (w_s2) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STABLE) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
          w_fall      = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
        default: w_state_nxt = IDLE_LOW;
      endcase
    end
  end
  // busy is registered from the next state so it tracks the WAIT states exactly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
      r_press <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      r_busy  <= (w_state_nxt == WAIT_HIGH) || (w_state_nxt == WAIT_LOW);
      if (w_rise) begin
        r_level <= 1'b1;
        r_press <= r_press + PRESS_W'(1);
      end
      if (w_fall) r_level <= 1'b0;
    end
  end
  assign btn_level   = r_level;
  assign rise_pulse  = r_rise;
  assign fall_pulse  = r_fall;
  assign busy        = r_busy;
  assign press_count = r_press;
endmodule
